// File: rtl/rat_reduce.sv
// rat_reduce: reduces an unsigned fraction num/den to lowest terms.
// A binary (Stein) GCD finds g, then two restoring dividers compute num/g
// and den/g in parallel. A zero denominator skips both phases and is
// reported through out_err.
module rat_reduce #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   input  logic [WIDTH-1:0] in_den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_num,
   output logic [WIDTH-1:0] out_den,
   output logic             out_err
);

   localparam int KW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_GCD, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] num_q, num_d, den_q, den_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [KW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_n_q, rem_n_d, quo_n_q, quo_n_d;
   logic [WIDTH-1:0] rem_d_q, rem_d_d, quo_d_q, quo_d_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_num_q, out_num_d, out_den_q, out_den_d;
   logic             out_err_q, out_err_d;

   logic [WIDTH:0]   rn_sh, rd_sh;
   logic [WIDTH-1:0] rn_nx, rd_nx, qn_nx, qd_nx;
   logic [WIDTH-1:0] gcd_val;

   assign in_ready  = (state_q == S_IDLE) & ~rst;
   assign out_valid = out_valid_q;
   assign out_num   = out_num_q;
   assign out_den   = out_den_q;
   assign out_err   = out_err_q;

   // Next-state logic: divider steps, GCD steps and the handshake FSM.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      k_d         = k_q;
      num_d       = num_q;
      den_d       = den_q;
      g_d         = g_q;
      cnt_d       = cnt_q;
      rem_n_d     = rem_n_q;
      quo_n_d     = quo_n_q;
      rem_d_d     = rem_d_q;
      quo_d_d     = quo_d_q;
      out_valid_d = out_valid_q;
      out_num_d   = out_num_q;
      out_den_d   = out_den_q;
      out_err_d   = out_err_q;

      // One restoring-division step each for num/g and den/g. The remainder
      // is always below g, so the WIDTH-bit subtraction cannot wrap.
      rn_sh = {rem_n_q, quo_n_q[WIDTH-1]};
      rd_sh = {rem_d_q, quo_d_q[WIDTH-1]};
      if (rn_sh >= {1'b0, g_q}) begin
         rn_nx = rn_sh[WIDTH-1:0] - g_q;
         qn_nx = {quo_n_q[WIDTH-2:0], 1'b1};
      end else begin
         rn_nx = rn_sh[WIDTH-1:0];
         qn_nx = {quo_n_q[WIDTH-2:0], 1'b0};
      end
      if (rd_sh >= {1'b0, g_q}) begin
         rd_nx = rd_sh[WIDTH-1:0] - g_q;
         qd_nx = {quo_d_q[WIDTH-2:0], 1'b1};
      end else begin
         rd_nx = rd_sh[WIDTH-1:0];
         qd_nx = {quo_d_q[WIDTH-2:0], 1'b0};
      end

      gcd_val = (a_q | b_q) << k_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_den == '0) begin
                  out_num_d   = in_num;
                  out_den_d   = '0;
                  out_err_d   = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  a_d     = in_num;
                  b_d     = in_den;
                  k_d     = '0;
                  num_d   = in_num;
                  den_d   = in_den;
                  state_d = S_GCD;
               end
            end
         end
         S_GCD: begin
            if (a_q == '0 || b_q == '0) begin
               g_d     = gcd_val;
               cnt_d   = '0;
               rem_n_d = '0;
               rem_d_d = '0;
               quo_n_d = num_q;
               quo_d_d = den_q;
               state_d = S_DIV;
            end else if (!a_q[0] && !b_q[0]) begin
               a_d = a_q >> 1;
               b_d = b_q >> 1;
               k_d = k_q + KW'(1);
            end else if (!a_q[0]) begin
               a_d = a_q >> 1;
            end else if (!b_q[0]) begin
               b_d = b_q >> 1;
            end else if (a_q >= b_q) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         S_DIV: begin
            rem_n_d = rn_nx;
            quo_n_d = qn_nx;
            rem_d_d = rd_nx;
            quo_d_d = qd_nx;
            cnt_d   = cnt_q + KW'(1);
            if (cnt_q == KW'(WIDTH - 1)) begin
               out_num_d   = qn_nx;
               out_den_d   = qd_nx;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; synchronous reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         k_q         <= '0;
         num_q       <= '0;
         den_q       <= '0;
         g_q         <= '0;
         cnt_q       <= '0;
         rem_n_q     <= '0;
         quo_n_q     <= '0;
         rem_d_q     <= '0;
         quo_d_q     <= '0;
         out_valid_q <= 1'b0;
         out_num_q   <= '0;
         out_den_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         k_q         <= k_d;
         num_q       <= num_d;
         den_q       <= den_d;
         g_q         <= g_d;
         cnt_q       <= cnt_d;
         rem_n_q     <= rem_n_d;
         quo_n_q     <= quo_n_d;
         rem_d_q     <= rem_d_d;
         quo_d_q     <= quo_d_d;
         out_valid_q <= out_valid_d;
         out_num_q   <= out_num_d;
         out_den_q   <= out_den_d;
         out_err_q   <= out_err_d;
      end
   end

endmodule

// File: tb/tb_rat_reduce.sv
// tb_rat_reduce: directed vectors for rat_reduce with hand-computed results.
module tb_rat_reduce;

   localparam int WIDTH = 32;
   localparam int LIMIT = 5 * WIDTH + 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_num;
   logic [WIDTH-1:0] in_den;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_num;
   logic [WIDTH-1:0] out_den;
   logic             out_err;

   int vectors;
   int miscompares;

   rat_reduce #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_den    (in_den),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num   (out_num),
      .out_den   (out_den),
      .out_err   (out_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a handshake never completes.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Present a pair at a negedge; it is accepted on the following posedge.
   task automatic startPair(input string tag, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
      in_num   = n;
      in_den   = d;
      in_valid = 1'b1;
      #1;
      checkOutput({tag, ".in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for out_valid (bounded), then check the result and that no
   // further pair was offered acceptance while busy.
   task automatic waitResult(input string tag, input logic [WIDTH-1:0] en,
                             input logic [WIDTH-1:0] ed, input logic ee, output int cyc);
      logic leak;
      cyc  = 1;
      leak = 1'b0;
      while (!out_valid && cyc < LIMIT + 8) begin
         if (in_ready) leak = 1'b1;
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, ".valid"}, out_valid, 1);
      checkOutput({tag, ".num"}, out_num, en);
      checkOutput({tag, ".den"}, out_den, ed);
      checkOutput({tag, ".err"}, out_err, ee);
      checkOutput({tag, ".busy_ready"}, leak, 0);
      checkOutput({tag, ".done_ready"}, in_ready, 0);
      checkOutput({tag, ".latency"}, cyc <= LIMIT, 1);
   endtask

   // Let the result drain and confirm the block is idle again.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".drain_valid"}, out_valid, 0);
      checkOutput({tag, ".drain_ready"}, in_ready, 1);
   endtask

   // One complete transaction with out_ready held high.
   task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] en, input logic [WIDTH-1:0] ed,
                                input logic ee, output int cyc);
      startPair(tag, n, d);
      waitResult(tag, en, ed, ee, cyc);
      drain(tag);
   endtask

   initial begin
      int   cyc;
      logic stable;
      logic leak;

      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_num      = '0;
      in_den      = '0;
      out_ready   = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("reset.valid", out_valid, 0);
      checkOutput("reset.num", out_num, 0);
      checkOutput("reset.den", out_den, 0);
      checkOutput("reset.err", out_err, 0);
      checkOutput("reset.in_ready", in_ready, 0);

      // First accept on the very first cycle after reset release.
      rst = 1'b0;
      applyStimulus("v6_8", 32'd6, 32'd8, 32'd3, 32'd4, 1'b0, cyc);
      applyStimulus("v0_5", 32'd0, 32'd5, 32'd0, 32'd1, 1'b0, cyc);
      applyStimulus("v12_12", 32'd12, 32'd12, 32'd1, 32'd1, 1'b0, cyc);
      applyStimulus("v7_1", 32'd7, 32'd1, 32'd7, 32'd1, 1'b0, cyc);
      applyStimulus("v100_75", 32'd100, 32'd75, 32'd4, 32'd3, 1'b0, cyc);
      applyStimulus("v7_0", 32'd7, 32'd0, 32'd7, 32'd0, 1'b1, cyc);
      checkOutput("v7_0.one_cycle", cyc, 1);
      applyStimulus("v0_0", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, cyc);
      applyStimulus("vpow2", 32'h8000_0000, 32'h4000_0000, 32'd2, 32'd1, 1'b0, cyc);
      applyStimulus("vcoprime", 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                    32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, cyc);

      // Backpressure: hold the result for 10 cycles while a second pair waits.
      out_ready = 1'b0;
      startPair("bp", 32'd6, 32'd8);
      waitResult("bp", 32'd3, 32'd4, 1'b0, cyc);
      in_num   = 32'd10;
      in_den   = 32'd4;
      in_valid = 1'b1;
      stable   = 1'b1;
      leak     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_num !== 32'd3 || out_den !== 32'd4 || out_err !== 1'b0)
            stable = 1'b0;
         if (in_ready) leak = 1'b1;
      end
      checkOutput("bp.hold_stable", stable, 1);
      checkOutput("bp.hold_ready", leak, 0);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp.drain_valid", out_valid, 0);
      checkOutput("bp.drain_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      waitResult("bp2", 32'd5, 32'd2, 1'b0, cyc);
      drain("bp2");

      // Reset in the middle of the DIV phase of 6/8.
      startPair("rst", 32'd6, 32'd8);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst.valid", out_valid, 0);
      checkOutput("rst.num", out_num, 0);
      checkOutput("rst.den", out_den, 0);
      checkOutput("rst.err", out_err, 0);
      checkOutput("rst.in_ready", in_ready, 0);
      rst  = 1'b0;
      leak = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) leak = 1'b1;
      end
      checkOutput("rst.no_stale", leak, 0);
      applyStimulus("v10_4", 32'd10, 32'd4, 32'd5, 32'd2, 1'b0, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
